// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg
//   Shared bus widths and default constants for the MEM-stage data RAM
//   responder and its byte-lane array.
package data_ram_responder_pkg;

   localparam int DATA_BUS      = 32;
   localparam int ADDR_BUS      = 32;
   localparam int MEM_SEL_BUS   = 4;
   localparam int DATA_RAM_WAIT = 1;
   localparam int WAIT_CNT_W    = 4;

   // Request fields that must survive past the IDLE sample.
   typedef struct packed {
      logic [MEM_SEL_BUS-1:0] we;
      logic [DATA_BUS-1:0]    wdata;
   } ram_req_t;

endpackage

// File: rtl/data_ram_array.sv
// data_ram_array
//   Four byte-lane synchronous single-port RAMs of 2^ADDR_WIDTH entries.
//   Per-lane write enable, registered read. The read register holds until
//   the next rd_en or rd_clr; rd_clr forces it to zero.
// Ports:
//   clk, rst_n       clock / async active-low reset (read register only)
//   rd_en            load rdata from mem[addr] on this edge
//   rd_clr           clear rdata on this edge (priority over rd_en)
//   addr             word index
//   we               byte-lane write enables
//   wdata            lane-aligned write data
//   rdata            registered read word
module data_ram_array
   import data_ram_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic                   rd_clr,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [MEM_SEL_BUS-1:0] we,
   input  logic [DATA_BUS-1:0]    wdata,
   output logic [DATA_BUS-1:0]    rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   for (genvar lane = 0; lane < MEM_SEL_BUS; lane++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we[lane]) begin
            mem[addr] <= wdata[8*lane +: 8];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata[8*lane +: 8] <= 8'h00;
         end else if (rd_clr) begin
            rdata[8*lane +: 8] <= 8'h00;
         end else if (rd_en) begin
            rdata[8*lane +: 8] <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder end of the MEM-stage data RAM interface. Latches a word-aligned
//   request, inserts WAIT_CYCLES wait states, then completes with a one-cycle
//   registered ram_ready pulse. Reads load ram_read_data on the edge entering
//   DONE; writes commit on the edge leaving DONE. Dropping ram_en during WAIT
//   aborts the access.
// Optional build macro:
//   DATA_RAM_ERR_EN  adds ram_err; addresses with bits above the word index
//                    set complete with ram_err=1, ram_read_data=0, no write.
//                    Without it, high address bits alias silently.
// Ports:
//   clk, rst_n       clock / async active-low reset
//   ram_en           request valid, held until ram_ready
//   ram_write_en     byte-lane write enables (0 = read)
//   ram_addr         byte address, [1:0] ignored
//   ram_write_data   lane-shifted write data
//   ram_read_data    read word, valid with ram_ready and held afterwards
//   ram_ready        completion pulse
//   ram_err          out-of-range completion pulse (DATA_RAM_ERR_EN only)
//
// state | meaning
// IDLE  | waiting for ram_en; latches the request
// WAIT  | counting wait states; ram_en low aborts
// DONE  | ram_ready high; write commits on exit
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = DATA_RAM_WAIT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ram_en,
   input  logic [MEM_SEL_BUS-1:0] ram_write_en,
   input  logic [ADDR_BUS-1:0]    ram_addr,
   input  logic [DATA_BUS-1:0]    ram_write_data,
   output logic [DATA_BUS-1:0]    ram_read_data,
   output logic                   ram_ready
`ifdef DATA_RAM_ERR_EN
   ,
   output logic                   ram_err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

   state_t                  state, state_nxt;
   logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
   ram_req_t                lat_req;
   logic [ADDR_WIDTH-1:0]   lat_idx;
   logic                    lat_oor;
   logic                    ready_r;
   logic                    err_r;

   logic                    in_oor;
   logic [ADDR_WIDTH-1:0]   in_idx;
   logic [MEM_SEL_BUS-1:0]  cur_we;
   logic [ADDR_WIDTH-1:0]   cur_idx;
   logic                    cur_oor;
   logic                    enter_done;
   logic                    arr_rd_en;
   logic                    arr_rd_clr;
   logic [MEM_SEL_BUS-1:0]  arr_we;
   logic                    unused_addr_bits;

   assign in_idx = ram_addr[ADDR_WIDTH+1:2];
`ifdef DATA_RAM_ERR_EN
   assign in_oor = |ram_addr[ADDR_BUS-1:ADDR_WIDTH+2];
`else
   assign in_oor = 1'b0;
`endif
   assign unused_addr_bits = ^{ram_addr[1:0], ram_addr[ADDR_BUS-1:ADDR_WIDTH+2]};

   // With WAIT_CYCLES=0 the IDLE->DONE edge must use the live request,
   // since the latch only updates on that same edge.
   assign cur_we  = (state == IDLE) ? ram_write_en : lat_req.we;
   assign cur_idx = (state == IDLE) ? in_idx       : lat_idx;
   assign cur_oor = (state == IDLE) ? in_oor       : lat_oor;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (ram_en) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!ram_en) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == 1) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_done = (state_nxt == DONE) && (state != DONE);
   assign arr_rd_clr = enter_done && cur_oor;
   assign arr_rd_en  = enter_done && (cur_we == '0) && !cur_oor;
   assign arr_we     = ((state == DONE) && !lat_oor) ? lat_req.we : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_req <= '0;
         lat_idx <= '0;
         lat_oor <= 1'b0;
         ready_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_r <= enter_done;
         err_r   <= enter_done && cur_oor;
         if ((state == IDLE) && ram_en) begin
            lat_req.we    <= ram_write_en;
            lat_req.wdata <= ram_write_data;
            lat_idx       <= in_idx;
            lat_oor       <= in_oor;
         end
      end
   end

   data_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  (arr_rd_en),
      .rd_clr (arr_rd_clr),
      .addr   (cur_idx),
      .we     (arr_we),
      .wdata  (lat_req.wdata),
      .rdata  (ram_read_data)
   );

   assign ram_ready = ready_r;
`ifdef DATA_RAM_ERR_EN
   assign ram_err = err_r;
`else
   logic unused_err;
   assign unused_err = err_r;
`endif

endmodule
